// File: rtl/alu_muldiv.sv
// EX-stage ALU: zero-latency combinational ops plus an iterative multiply/divide engine with HI/LO.
// Optional `overflow` output for ADD/SUB when the ALU_OVF_EN macro is defined.
module alu_muldiv #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic [3:0]       alu_op,
  input  logic [SHW-1:0]   shamt,
  input  logic             start,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef ALU_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SLT   = 4'b0011;
  localparam logic [3:0] OP_SLTU  = 4'b0100;
  localparam logic [3:0] OP_DIVU  = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_XOR   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MULT  = 4'b1101;
  localparam logic [3:0] OP_MULTU = 4'b1110;
  localparam logic [3:0] OP_DIV   = 4'b1111;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [SHW-1:0]     count;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   a_raw;
  logic               is_div;
  logic               neg_lo;
  logic               neg_hi;
  logic               dvz;

  logic [WIDTH-1:0]   add_res;
  logic [WIDTH-1:0]   sub_res;

  assign add_res = alu_a + alu_b;
  assign sub_res = alu_a - alu_b;

  // Combinational result path
  always_comb begin
    alu_out = '0;
    case (alu_op)
      OP_ADD:  alu_out = add_res;
      OP_SUB:  alu_out = sub_res;
      OP_AND:  alu_out = alu_a & alu_b;
      OP_OR:   alu_out = alu_a | alu_b;
      OP_XOR:  alu_out = alu_a ^ alu_b;
      OP_NOR:  alu_out = ~(alu_a | alu_b);
      OP_SLT:  alu_out = WIDTH'($signed(alu_a) < $signed(alu_b));
      OP_SLTU: alu_out = WIDTH'(alu_a < alu_b);
      OP_SLL:  alu_out = alu_b << shamt;
      OP_SRL:  alu_out = alu_b >> shamt;
      OP_SRA:  alu_out = $signed(alu_b) >>> shamt;
      default: alu_out = '0;
    endcase
  end

  assign zero = (alu_out == '0);

`ifdef ALU_OVF_EN
  always_comb begin
    overflow = 1'b0;
    case (alu_op)
      OP_ADD:  overflow = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (add_res[WIDTH-1] != alu_a[WIDTH-1]);
      OP_SUB:  overflow = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (sub_res[WIDTH-1] != alu_a[WIDTH-1]);
      default: overflow = 1'b0;
    endcase
  end
`endif

  // Launch decode: signed ops work on magnitudes, signs are restored at the end
  logic             is_md;
  logic             is_sgn;
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  always_comb begin
    is_md  = (alu_op == OP_MULT) || (alu_op == OP_MULTU) || (alu_op == OP_DIV) || (alu_op == OP_DIVU);
    is_sgn = (alu_op == OP_MULT) || (alu_op == OP_DIV);
    sa     = is_sgn & alu_a[WIDTH-1];
    sb     = is_sgn & alu_b[WIDTH-1];
    mag_a  = sa ? -alu_a : alu_a;
    mag_b  = sb ? -alu_b : alu_b;
  end

  // One shift-add or restoring-subtract step on {upper, lower} of acc
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     rem_sh;
  logic               rem_lt;
  logic [WIDTH-1:0]   rem_sub;
  logic [2*WIDTH-1:0] acc_step;

  always_comb begin
    add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    rem_lt   = rem_sh < {1'b0, opnd};
    rem_sub  = rem_sh[WIDTH-1:0] - opnd;
    acc_step = {add_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (rem_lt) acc_step = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else        acc_step = {rem_sub, acc[WIDTH-2:0], 1'b1};
    end
  end

  // Sign fix-up and divide-by-zero override applied on the final step
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   hi_nxt;
  logic [WIDTH-1:0]   lo_nxt;

  always_comb begin
    prod_fix = neg_lo ? -acc_step : acc_step;
    hi_nxt   = prod_fix[2*WIDTH-1:WIDTH];
    lo_nxt   = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (dvz) begin
        hi_nxt = a_raw;
        lo_nxt = '1;
      end else begin
        hi_nxt = neg_hi ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
        lo_nxt = neg_lo ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      acc    <= '0;
      opnd   <= '0;
      a_raw  <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      dvz    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && is_md) begin
            state  <= RUN;
            busy   <= 1'b1;
            count  <= SHW'(WIDTH - 1);
            is_div <= (alu_op == OP_DIV) || (alu_op == OP_DIVU);
            neg_lo <= sa ^ sb;
            neg_hi <= sa;
            dvz    <= (alu_b == '0);
            a_raw  <= alu_a;
            if ((alu_op == OP_DIV) || (alu_op == OP_DIVU)) begin
              acc  <= {{WIDTH{1'b0}}, mag_a};
              opnd <= mag_b;
            end else begin
              acc  <= {{WIDTH{1'b0}}, mag_b};
              opnd <= mag_a;
            end
          end
        end
        RUN: begin
          acc   <= acc_step;
          count <= count - 1'b1;
          if (count == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            hi    <= hi_nxt;
            lo    <= lo_nxt;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: random + directed ops against an arithmetic reference model.
module tb_alu_muldiv;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SLT   = 4'b0011;
  localparam logic [3:0] OP_SLTU  = 4'b0100;
  localparam logic [3:0] OP_DIVU  = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_XOR   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MULT  = 4'b1101;
  localparam logic [3:0] OP_MULTU = 4'b1110;
  localparam logic [3:0] OP_DIV   = 4'b1111;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [4:0]  shamt;
  logic        start;
  logic [31:0] alu_out;
  logic        zero;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
`ifdef ALU_OVF_EN
  logic        overflow;
`endif

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t sb_q[$];
  exp_t last;

  alu_muldiv #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .rst(rst), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .shamt(shamt), .start(start), .alu_out(alu_out), .zero(zero),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
`ifdef ALU_OVF_EN
    , .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] comb_model(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [4:0] sh);
    longint sbv;
    sbv = $signed(b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      OP_SLL:  return a * 0 + (b << sh);
      OP_SRL:  return b >> sh;
      OP_SRA:  return 32'(sbv / (64'sd1 <<< sh) - ((sbv < 0 && (sbv % (64'sd1 <<< sh)) != 0) ? 1 : 0));
      default: return 32'd0;
    endcase
  endfunction

  function automatic exp_t md_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa;
    longint          sbv;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     p;
    exp_t            r;
    sa  = $signed(a);
    sbv = $signed(b);
    ua  = a;
    ub  = b;
    r   = '0;
    case (op)
      OP_MULT:  begin p = 64'(sa * sbv); r.hi = p[63:32]; r.lo = p[31:0]; end
      OP_MULTU: begin p = ua * ub;       r.hi = p[63:32]; r.lo = p[31:0]; end
      OP_DIV: begin
        if (b == 32'd0) begin r.hi = a; r.lo = 32'hFFFF_FFFF; end
        else begin r.lo = 32'(sa / sbv); r.hi = 32'(sa % sbv); end
      end
      default: begin
        if (b == 32'd0) begin r.hi = a; r.lo = 32'hFFFF_FFFF; end
        else begin r.lo = 32'(ua / ub); r.hi = 32'(ua % ub); end
      end
    endcase
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check("hi", 64'(hi), 64'(e.hi));
          check("lo", 64'(lo), 64'(e.lo));
        end
      end
    end
  end

  task automatic comb_check(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] sh);
    logic [31:0] e;
    @(negedge clk);
    alu_op = op; alu_a = a; alu_b = b; shamt = sh;
    #1;
    e = comb_model(op, a, b, sh);
    check($sformatf("alu_out op%0h", op), 64'(alu_out), 64'(e));
    check($sformatf("zero op%0h", op), 64'(zero), 64'(e == 32'd0));
  endtask

  task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit poke);
    int   dk;
    int   nb;
    exp_t e;
    check("hold_hi", 64'(hi), 64'(last.hi));
    check("hold_lo", 64'(lo), 64'(last.lo));
    e = md_model(op, a, b);
    @(negedge clk);
    alu_op = op; alu_a = a; alu_b = b; start = 1'b1;
    sb_q.push_back(e);
    last = e;
    @(posedge clk);
    #1;
    start  = 1'b0;
    alu_a  = $urandom;
    alu_b  = $urandom;
    alu_op = 4'($urandom);
    dk = 0;
    nb = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy) nb++;
      if (poke && k == 5) begin start = 1'b1; alu_op = OP_MULTU; end
      if (poke && k == 6) start = 1'b0;
      if (done) begin dk = k; break; end
    end
    check("done_cycle", 64'(dk), 64'd33);
    check("busy_cycles", 64'(nb), 64'd32);
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 300));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] md_ops[4];
    md_ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
    rst = 1'b1; start = 1'b0; alu_a = '0; alu_b = '0; alu_op = OP_AND; shamt = '0;
    last = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    rst = 1'b0;

    comb_check(OP_AND,  32'h0000_000F, 32'hFFFF_FFF0, 5'd0);
    comb_check(OP_OR,   32'h0000_000F, 32'hFFFF_FFF0, 5'd0);
    comb_check(OP_NOR,  32'h0000_000F, 32'hFFFF_FFF0, 5'd0);
    comb_check(OP_SLT,  32'h0000_000F, 32'hFFFF_FFF0, 5'd0);
    comb_check(OP_SLTU, 32'h0000_000F, 32'hFFFF_FFF0, 5'd0);
    comb_check(OP_SRA,  32'h0000_000F, 32'hFFFF_FFF0, 5'd4);
    comb_check(OP_SRL,  32'h0000_000F, 32'hFFFF_FFF0, 5'd4);
    for (int i = 0; i < 150; i++)
      comb_check(4'($urandom), rand_opnd(), rand_opnd(), 5'($urandom));

    // start with a non-mul/div op must not launch the engine
    @(negedge clk);
    alu_op = OP_ADD; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("nonmd_start_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("nonmd_start_done", 64'(done), 64'd0);

    run_md(OP_MULTU, 32'd7, 32'd6, 1'b0);
    run_md(OP_MULT,  32'hFFFF_FFFD, 32'd5, 1'b0);
    run_md(OP_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);
    run_md(OP_DIVU,  32'd100, 32'd7, 1'b0);
    run_md(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_md(OP_DIVU,  32'd5, 32'd0, 1'b1);
    run_md(OP_DIV,   32'hFFFF_FFF7, 32'd0, 1'b0);

    // reset in RUN cycle 10 aborts without a done pulse
    @(negedge clk);
    alu_op = OP_DIVU; alu_a = 32'd1000; alu_b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    last = '0;
    repeat (40) @(negedge clk);
    run_md(OP_MULTU, 32'd123, 32'd456, 1'b0);

    for (int i = 0; i < 24; i++)
      run_md(md_ops[$urandom_range(0, 3)], rand_opnd(), rand_opnd(), 1'($urandom));

`ifdef ALU_OVF_EN
    comb_check(OP_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0);
    check("ovf_add", 64'(overflow), 64'd1);
    comb_check(OP_SUB, 32'h8000_0000, 32'd1, 5'd0);
    check("ovf_sub", 64'(overflow), 64'd1);
    comb_check(OP_ADD, 32'd1, 32'd1, 5'd0);
    check("ovf_none", 64'(overflow), 64'd0);
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
